// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, canonical NOP and fetch FSM states.
package core_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0,x0,0; also used by IF/ID clear logic
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    REQ  = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Single-entry instruction/PC output buffer between the fetch FSM and IF/ID.
module fetch_buffer #(
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pcInc_o,
  output logic        valid_o,
  output logic        free_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        consume;

  assign consume = valid_q & ~stall_i;
  assign free_o  = ~valid_q | consume;

  // Next buffer contents: flush beats load, load beats consume
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  // Buffer registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  // Present NOP and zero PCs whenever the buffer is empty
  always_comb begin
    instr_o = valid_q ? instr_q : NOP_INSTR;
    pc_o    = valid_q ? pc_q : '0;
    pcInc_o = valid_q ? (pc_q + 32'd4) : '0;
    valid_o = valid_q;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request,
// and hands fetched instructions to IF/ID through fetch_buffer.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pcInc_o,
  output logic        instr_valid_o
);

  import core_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         discard_q, discard_d;
  logic         buf_free;
  logic         buf_load;
  logic         req_valid;

  // Next-state, PC and request logic; redirect dominates everything but reset
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    buf_load  = 1'b0;
    req_valid = 1'b0;
    if (redirect_i) begin
      pc_d = {redirect_pc_i[31:2], 2'b00};
      if (state_q == WAIT) begin
        if (imem_rsp_valid_i) begin
          // in-flight response belongs to the old path and is consumed here
          discard_d = 1'b0;
          state_d   = REQ;
        end else begin
          discard_d = 1'b1;
        end
      end
    end else begin
      unique case (state_q)
        REQ: begin
          req_valid = buf_free;
          if (buf_free && imem_req_ready_i) state_d = WAIT;
        end
        WAIT: begin
          if (imem_rsp_valid_i) begin
            state_d = REQ;
            if (discard_q) begin
              discard_d = 1'b0;
            end else begin
              buf_load = 1'b1;
              pc_d     = pc_q + 32'd4;
            end
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  // FSM, PC and discard registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = pc_q;

  fetch_buffer #(
    .NOP_INSTR(NOP_INSTR)
  ) u_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (buf_load),
    .flush_i (redirect_i),
    .stall_i (stall_i),
    .instr_i (imem_rsp_data_i),
    .pc_i    (pc_q),
    .instr_o (instr_o),
    .pc_o    (pc_o),
    .pcInc_o (pcInc_o),
    .valid_o (instr_valid_o),
    .free_o  (buf_free)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench plays instruction memory cycle by
// cycle; accepted responses are queued as expectations and popped on load.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pcInc_o;
  logic        instr_valid_o;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .instr_o          (instr_o),
    .pc_o             (pc_o),
    .pcInc_o          (pcInc_o),
    .instr_valid_o    (instr_valid_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_instr"}, instr_o, NOP);
    check({tag, "_pc"}, pc_o, 32'h0);
    check({tag, "_pcinc"}, pcInc_o, 32'h0);
    check({tag, "_valid"}, {31'b0, instr_valid_o}, 32'h0);
  endtask

  task automatic check_req(input string tag, input logic vld, input logic [31:0] addr);
    check({tag, "_reqv"}, {31'b0, imem_req_valid_o}, {31'b0, vld});
    if (vld) check({tag, "_addr"}, imem_req_addr_o, addr);
  endtask

  // Pop the scoreboard and compare it with the presented buffer
  task automatic check_load(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'h1, 32'h0);
    end else begin
      e = sb.pop_front();
      check({tag, "_valid"}, {31'b0, instr_valid_o}, 32'h1);
      check({tag, "_instr"}, instr_o, e.instr);
      check({tag, "_pc"}, pc_o, e.pc);
      check({tag, "_pcinc"}, pcInc_o, e.pc + 32'd4);
    end
  endtask

  // One complete fetch: request at addr accepted, response after lat cycles
  task automatic fetch(input string tag, input logic [31:0] addr,
                       input logic [31:0] data, input int unsigned lat);
    imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0;
    #1;
    check_req({tag, "_req"}, 1'b1, addr);
    tick();
    imem_req_ready_i = 1'b0;
    for (int unsigned i = 1; i < lat; i++) begin
      check_req({tag, "_wait"}, 1'b0, addr);
      tick();
    end
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = data;
    sb.push_back('{instr: data, pc: addr});
    tick();
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    check_load(tag);
  endtask

  initial begin
    rst_n            = 1'b0;
    stall_i          = 1'b0;
    redirect_i       = 1'b0;
    redirect_pc_i    = '0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    tick();
    tick();
    check_empty("reset");
    rst_n = 1'b1;
    #1;

    // 1: first fetch from RESET_PC, 1-cycle latency
    fetch("t1_first", 32'h0, 32'h0050_0093, 1);

    // 2: second fetch, then stall with a valid buffer
    fetch("t2_second", 32'h4, 32'h0010_0113, 1);
    stall_i          = 1'b1;
    imem_req_ready_i = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      check_req("t2_stall", 1'b0, 32'h0);
      check("t2_stall_instr", instr_o, 32'h0010_0113);
      check("t2_stall_pc", pc_o, 32'h4);
      check("t2_stall_valid", {31'b0, instr_valid_o}, 32'h1);
      tick();
    end
    stall_i = 1'b0;
    #1;
    check_req("t2_release", 1'b1, 32'h8);

    // 3: request at 0x8 accepted, redirect next cycle, response 2 cycles later
    tick();
    imem_req_ready_i = 1'b0;
    redirect_i       = 1'b1;
    redirect_pc_i    = 32'h0000_0100;
    #1;
    check_req("t3_redir", 1'b0, 32'h0);
    tick();
    redirect_i = 1'b0;
    check_empty("t3_flushed");
    tick();
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid_i = 1'b0;
    check_empty("t3_dropped");
    imem_req_ready_i = 1'b1;
    #1;
    check_req("t3_newreq", 1'b1, 32'h100);

    // 4: redirect to 0x203 coinciding with the WAIT response
    tick();
    imem_req_ready_i = 1'b0;
    redirect_i       = 1'b1;
    redirect_pc_i    = 32'h0000_0203;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'hCAFE_F00D;
    tick();
    redirect_i       = 1'b0;
    imem_rsp_valid_i = 1'b0;
    check_empty("t4_dropped");
    fetch("t4_masked", 32'h200, 32'h0020_8193, 1);

    // 5: memory not ready for 4 cycles, request holds, then latency-2 fetch
    imem_req_ready_i = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      #1;
      check_req("t5_hold", 1'b1, 32'h204);
      tick();
    end
    fetch("t5_ready", 32'h204, 32'h0031_8213, 2);

    // Wrap: fetch at 0xFFFFFFFC, PC+4 wraps to zero
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFE;
    tick();
    redirect_i = 1'b0;
    fetch("wrap", 32'hFFFF_FFFC, 32'h0000_0073, 1);
    #1;
    check_req("wrap_next", 1'b1, 32'h0);

    // 6: reset while WAIT, stale response afterwards is ignored
    imem_req_ready_i = 1'b1;
    tick();
    imem_req_ready_i = 1'b0;
    rst_n            = 1'b0;
    tick();
    rst_n            = 1'b1;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'hBAD0_BAD0;
    #1;
    check_empty("t6_after_rst");
    check_req("t6_req", 1'b1, 32'h0);
    tick();
    imem_rsp_valid_i = 1'b0;
    check_empty("t6_stale");
    fetch("t6_refetch", 32'h0, 32'h0040_0293, 1);

    check("sb_drained", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
